// File: rtl/usb_fs_link_ctrl.sv
// Full-speed USB link-state controller: tracks attach, bus reset, suspend/resume
// and SOF-based host presence, and holds the protocol engine in link reset.
`timescale 1ns/1ps
module usb_fs_link_ctrl #(
    parameter int unsigned ResetDetCycles = 120,
    parameter int unsigned SuspendCycles  = 144000,
    parameter int unsigned FrameCycles    = 48000,
    parameter int unsigned HostLostFrames = 4
) (
    input  logic       clk_48mhz_i,
    input  logic       rst_ni,
    input  logic       usb_sense_i,
    input  logic       connect_en_i,
    input  logic       usb_d_i,
    input  logic       usb_se0_i,
    input  logic       usb_oe_i,
    input  logic       sof_valid_i,
    output logic [2:0] link_state_o,
    output logic       link_reset_o,
    output logic       link_suspend_o,
    output logic       link_resume_o,
    output logic       link_disconnect_o,
    output logic       host_lost_o
);
    localparam int SeW = $clog2(ResetDetCycles + 1);
    localparam int IdW = $clog2(SuspendCycles + 1);
    localparam int FrW = $clog2(FrameCycles + 1);
    localparam int MsW = $clog2(HostLostFrames + 1);

    localparam logic [SeW-1:0] SeMax    = SeW'(ResetDetCycles);
    localparam logic [IdW-1:0] IdMax    = IdW'(SuspendCycles);
    localparam logic [FrW-1:0] FrLast   = FrW'(FrameCycles - 1);
    localparam logic [MsW-1:0] MsMax    = MsW'(HostLostFrames);
    localparam logic [MsW-1:0] MsPenult = MsW'(HostLostFrames - 1);

    typedef enum logic [2:0] {
        StDisc      = 3'd0,
        StPowered   = 3'd1,
        StActNoSof  = 3'd2,
        StActive    = 3'd3,
        StSuspended = 3'd4,
        StResuming  = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [SeW-1:0] se0_cnt_q, se0_cnt_d;
    logic [IdW-1:0] idle_cnt_q, idle_cnt_d;
    logic [FrW-1:0] frame_q, frame_d;
    logic [MsW-1:0] missed_q, missed_d;
    logic           reset_det_q, reset_det_d;
    logic           k_prev_q, se0_prev_q;
    logic           lreset_q, susp_q, resume_q, disc_q, host_q, host_d;

    logic samp_vld, is_se0, is_j, is_k, connected, reset_fall, rule3, in_act;

    // Line is only meaningful while we are not driving it ourselves.
    assign samp_vld   = ~usb_oe_i;
    assign is_se0     = samp_vld & usb_se0_i;
    assign is_j       = samp_vld & usb_d_i & ~usb_se0_i;
    assign is_k       = samp_vld & ~usb_d_i & ~usb_se0_i;
    assign connected  = usb_sense_i & connect_en_i;
    assign reset_fall = reset_det_q & samp_vld & ~usb_se0_i;
    assign rule3      = connected & (state_q != StDisc) & reset_fall;
    assign in_act     = (state_q == StActNoSof) | (state_q == StActive);

    always_comb begin
        se0_cnt_d   = '0;
        idle_cnt_d  = '0;
        reset_det_d = reset_det_q;
        if (is_se0) begin
            se0_cnt_d   = (se0_cnt_q == SeMax) ? se0_cnt_q : se0_cnt_q + SeW'(1);
            reset_det_d = reset_det_q | (se0_cnt_d == SeMax);
        end else if (samp_vld) begin
            reset_det_d = 1'b0;
        end
        if (is_j) begin
            idle_cnt_d = (idle_cnt_q == IdMax) ? idle_cnt_q : idle_cnt_q + IdW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!connected) begin
            state_d = StDisc;
        end else if (state_q == StDisc) begin
            state_d = StPowered;
        end else if (reset_fall) begin
            state_d = StActNoSof;
        end else begin
            case (state_q)
                StActNoSof, StActive: begin
                    if (idle_cnt_d == IdMax)                   state_d = StSuspended;
                    else if (state_q == StActNoSof && sof_valid_i) state_d = StActive;
                end
                StSuspended: if (k_prev_q && is_k)  state_d = StResuming;
                StResuming:  if (se0_prev_q && is_j) state_d = StActive;
                default: ;
            endcase
        end
    end

    // Frame timer only runs in ACTIVE; SOF or a completed bus reset restarts it.
    always_comb begin
        frame_d  = frame_q;
        missed_d = missed_q;
        host_d   = 1'b0;
        if (rule3 || (sof_valid_i && in_act)) begin
            frame_d  = '0;
            missed_d = '0;
        end else if (state_q == StActive) begin
            if (frame_q == FrLast) begin
                frame_d  = '0;
                missed_d = (missed_q == MsMax) ? missed_q : missed_q + MsW'(1);
                host_d   = (missed_q == MsPenult);
            end else begin
                frame_d = frame_q + FrW'(1);
            end
        end
    end

    always_ff @(posedge clk_48mhz_i) begin
        if (!rst_ni) begin
            state_q     <= StDisc;
            se0_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            frame_q     <= '0;
            missed_q    <= '0;
            reset_det_q <= 1'b0;
            k_prev_q    <= 1'b0;
            se0_prev_q  <= 1'b0;
            lreset_q    <= 1'b1;
            susp_q      <= 1'b0;
            resume_q    <= 1'b0;
            disc_q      <= 1'b0;
            host_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            se0_cnt_q   <= se0_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            frame_q     <= frame_d;
            missed_q    <= missed_d;
            reset_det_q <= reset_det_d;
            k_prev_q    <= is_k;
            se0_prev_q  <= is_se0;
            lreset_q    <= (state_d == StDisc) | reset_det_d;
            susp_q      <= (state_d == StSuspended) & (state_q != StSuspended);
            resume_q    <= (state_q == StResuming) & (state_d == StActive);
            disc_q      <= (state_d == StDisc) & (state_q != StDisc);
            host_q      <= host_d;
        end
    end

    assign link_state_o      = state_q;
    assign link_reset_o      = lreset_q;
    assign link_suspend_o    = susp_q;
    assign link_resume_o     = resume_q;
    assign link_disconnect_o = disc_q;
    assign host_lost_o       = host_q;
endmodule

// File: tb/tb_usb_fs_link_ctrl.sv
// Directed bench for usb_fs_link_ctrl with a run-length based reference model
// compared against every output on every cycle.
`timescale 1ns/1ps
module tb_usb_fs_link_ctrl;
    localparam int RD = 8, SC = 64, FC = 100, HL = 3;
    localparam int S_DISC = 0, S_PWR = 1, S_NOSOF = 2, S_ACT = 3, S_SUSP = 4, S_RES = 5;
    localparam int K_NONE = 0, K_SE0 = 1, K_J = 2, K_K = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sense = 1'b0, en = 1'b0, d = 1'b1, se0 = 1'b0, oe = 1'b0, sof = 1'b0;
    logic [2:0] st;
    logic       lreset, susp, resume, disc, host;

    int total = 0, bad = 0;
    int n_susp = 0, n_resume = 0, n_disc = 0, n_host = 0;
    bit chk_en = 0;

    usb_fs_link_ctrl #(
        .ResetDetCycles(RD), .SuspendCycles(SC), .FrameCycles(FC), .HostLostFrames(HL)
    ) dut (
        .clk_48mhz_i(clk), .rst_ni(rst_n), .usb_sense_i(sense), .connect_en_i(en),
        .usb_d_i(d), .usb_se0_i(se0), .usb_oe_i(oe), .sof_valid_i(sof),
        .link_state_o(st), .link_reset_o(lreset), .link_suspend_o(susp),
        .link_resume_o(resume), .link_disconnect_o(disc), .host_lost_o(host)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run lengths of line symbols, elapsed cycles in frame,
    // and an unbounded missed-frame count.
    int m_state = S_DISC, se0_run = 0, j_run = 0, prev_kind = K_NONE;
    int elapsed = 0, missed = 0;
    bit m_rdet = 0, m_lreset = 1, m_susp = 0, m_resume = 0, m_disc = 0, m_host = 0;

    always @(posedge clk) begin
        int kind, nxt;
        bit fall, r3;
        if (!rst_n) begin
            m_state = S_DISC; se0_run = 0; j_run = 0; prev_kind = K_NONE;
            elapsed = 0; missed = 0; m_rdet = 0;
            m_lreset = 1; m_susp = 0; m_resume = 0; m_disc = 0; m_host = 0;
        end else begin
            kind    = oe ? K_NONE : se0 ? K_SE0 : d ? K_J : K_K;
            se0_run = (kind == K_SE0) ? se0_run + 1 : 0;
            j_run   = (kind == K_J) ? j_run + 1 : 0;
            fall    = m_rdet && (kind == K_J || kind == K_K);
            if (kind == K_SE0 && se0_run >= RD) m_rdet = 1;
            else if (kind == K_J || kind == K_K) m_rdet = 0;
            nxt = m_state; r3 = 0;
            if (!(sense && en)) nxt = S_DISC;
            else if (m_state == S_DISC) nxt = S_PWR;
            else if (fall) begin nxt = S_NOSOF; r3 = 1; end
            else if ((m_state == S_NOSOF || m_state == S_ACT) && j_run >= SC) nxt = S_SUSP;
            else if (m_state == S_SUSP && prev_kind == K_K && kind == K_K) nxt = S_RES;
            else if (m_state == S_RES && prev_kind == K_SE0 && kind == K_J) nxt = S_ACT;
            else if (m_state == S_NOSOF && sof) nxt = S_ACT;
            m_host = 0;
            if (r3 || (sof && (m_state == S_NOSOF || m_state == S_ACT))) begin
                elapsed = 0; missed = 0;
            end else if (m_state == S_ACT) begin
                elapsed++;
                if (elapsed == FC) begin
                    elapsed = 0; missed++;
                    m_host = (missed == HL);
                end
            end
            m_susp   = (nxt == S_SUSP) && (m_state != S_SUSP);
            m_resume = (m_state == S_RES) && (nxt == S_ACT);
            m_disc   = (nxt == S_DISC) && (m_state != S_DISC);
            m_lreset = (nxt == S_DISC) || m_rdet;
            prev_kind = kind;
            m_state   = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("state", int'(st), m_state);
            cmp("link_reset", int'(lreset), int'(m_lreset));
            cmp("suspend_pulse", int'(susp), int'(m_susp));
            cmp("resume_pulse", int'(resume), int'(m_resume));
            cmp("disconnect_pulse", int'(disc), int'(m_disc));
            cmp("host_lost_pulse", int'(host), int'(m_host));
            if (susp === 1'b1)   n_susp++;
            if (resume === 1'b1) n_resume++;
            if (disc === 1'b1)   n_disc++;
            if (host === 1'b1)   n_host++;
        end
    end

    // Drive one line symbol for n sampling edges; returns 1ns after the last edge.
    task automatic drv(input logic s0, input logic dd, input logic o, input logic sf, input int n);
        repeat (n) begin
            se0 = s0; d = dd; oe = o; sof = sf;
            @(posedge clk); #1;
        end
        sof = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        cmp("rst_state", int'(st), S_DISC);
        cmp("rst_link_reset", int'(lreset), 1);
        cmp("rst_pulses", int'({susp, resume, disc, host}), 0);

        rst_n = 1; sense = 1; en = 1;
        drv(0, 1, 0, 0, 1);
        cmp("s1_powered", int'(st), S_PWR);
        drv(1, 0, 0, 0, RD);
        cmp("s1_reset_det", int'(lreset), 1);
        cmp("s1_still_powered", int'(st), S_PWR);
        drv(0, 1, 0, 0, 1);
        cmp("s1_nosof", int'(st), S_NOSOF);
        cmp("s1_reset_released", int'(lreset), 0);

        drv(0, 1, 0, 1, 1);
        cmp("s2_active", int'(st), S_ACT);
        drv(1, 0, 0, 0, RD - 1);
        cmp("s2_short_se0_no_reset", int'(lreset), 0);
        drv(0, 1, 0, 0, 1);
        cmp("s2_stays_active", int'(st), S_ACT);

        drv(0, 0, 0, 0, 1);
        drv(0, 1, 0, 0, SC - 1);
        cmp("s3_63j_active", int'(st), S_ACT);
        drv(0, 1, 0, 0, 1);
        cmp("s3_suspended", int'(st), S_SUSP);
        cmp("s3_suspend_pulse", int'(susp), 1);

        drv(0, 0, 0, 0, 1);
        cmp("s4_one_k", int'(st), S_SUSP);
        drv(0, 0, 0, 0, 1);
        cmp("s4_resuming", int'(st), S_RES);
        drv(1, 0, 0, 0, 1);
        drv(0, 1, 0, 0, 1);
        cmp("s4_resumed", int'(st), S_ACT);
        cmp("s4_resume_pulse", int'(resume), 1);
        drv(0, 0, 0, 0, 1);
        drv(0, 1, 0, 0, SC - 1);
        drv(0, 0, 0, 0, 1);
        cmp("s3_63j_then_k", int'(st), S_ACT);
        cmp("s3_suspend_count", n_susp, 1);
        drv(0, 1, 0, 0, SC);
        cmp("s4_suspended_again", int'(st), S_SUSP);
        drv(1, 0, 0, 0, RD);
        drv(0, 1, 0, 0, 1);
        cmp("s4_bus_reset_from_suspend", int'(st), S_NOSOF);

        drv(0, 0, 0, 1, 1);
        cmp("s5_active", int'(st), S_ACT);
        drv(0, 0, 0, 0, 3 * FC - 1);
        cmp("s5_no_early_host_lost", n_host, 0);
        drv(0, 0, 0, 0, 1);
        cmp("s5_host_lost_pulse", int'(host), 1);
        drv(0, 0, 0, 0, 50);
        cmp("s5_host_lost_once", n_host, 1);
        cmp("s5_state_kept", int'(st), S_ACT);
        drv(0, 0, 0, 1, 1);
        drv(0, 0, 0, 0, 2 * FC - 1);
        drv(0, 0, 0, 1, 1);
        drv(0, 0, 0, 0, 2 * FC + 50);
        cmp("s5_sof_beats_expiry", n_host, 1);

        sense = 0;
        drv(0, 1, 0, 0, 1);
        cmp("s6_disconnected", int'(st), S_DISC);
        cmp("s6_disc_pulse", int'(disc), 1);
        cmp("s6_link_reset", int'(lreset), 1);
        sense = 1;
        drv(0, 1, 0, 0, 1);
        drv(1, 0, 0, 0, RD);
        drv(0, 1, 0, 0, 1);
        drv(0, 1, 0, 1, 1);
        cmp("s6_active_again", int'(st), S_ACT);
        drv(0, 1, 1, 0, 200);
        cmp("s6_oe_blocks_suspend", int'(st), S_ACT);
        drv(0, 1, 0, 0, 5);
        cmp("s6_after_oe_active", int'(st), S_ACT);

        rst_n = 0;
        drv(0, 1, 0, 0, 1);
        cmp("mid_reset_state", int'(st), S_DISC);
        cmp("mid_reset_link_reset", int'(lreset), 1);
        rst_n = 1;
        drv(0, 1, 0, 0, 1);
        cmp("post_reset_powered", int'(st), S_PWR);
        drv(0, 1, 0, 0, 2);

        cmp("final_suspend_count", n_susp, 2);
        cmp("final_resume_count", n_resume, 1);
        cmp("final_disconnect_count", n_disc, 1);
        cmp("final_host_lost_count", n_host, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
